// File: rtl/regbank_6502_if.sv
// -----------------------------------------------------------------------------
// regbank_6502_if
// Decoded bus-side handshake between the 6502 bus interface and the register
// bank. Strobes are single-cycle and are synchronous to clk_int50.
//
//   wr_stb  one-cycle write strobe          (master -> slave)
//   rd_stb  one-cycle read strobe           (master -> slave)
//   addr    4-bit register select           (master -> slave)
//   wdata   8-bit write data                (master -> slave)
//   rdata   8-bit registered read data      (slave  -> master)
//   rvalid  rdata valid for one cycle       (slave  -> master)
// -----------------------------------------------------------------------------
interface regbank_6502_if;
   logic       wr_stb;
   logic       rd_stb;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;
   logic       rvalid;

   modport master (output wr_stb, rd_stb, addr, wdata, input  rdata, rvalid);
   modport slave  (input  wr_stb, rd_stb, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/regbank_6502.sv
// -----------------------------------------------------------------------------
// regbank_6502
// Register bank and interval timer behind the 6502 bus interface. Holds the
// LED register, a 16-bit down-counting timer driven by a prescaler, an expiry
// status flag and an active-low interrupt.
//
// Parameters
//   PRESCALE  clk_int50 cycles per timer tick (1..65535)
//   LED_RST   reset value of the LED register
//
// Ports
//   clk_int50  in   internal 50 MHz clock, rising edge
//   rst        in   synchronous active-high reset
//   bus        slave modport of regbank_6502_if (strobes, addr, wdata,
//                    rdata, rvalid)
//   led        out  LED register (PWM-gated when the option is built in)
//   irq_n      out  active-low interrupt, registered
//
// Register map
//   0 LED | 1 CTRL (b0 EN, b1 AUTO, b2 IRQEN) | 2 RELLO | 3 RELHI |
//   4 CNTLO (ro, snapshots CNT[15:8]) | 5 CNTHI (ro, snapshot) |
//   6 STATUS (b0 EXP, write 1 clears) | 7 SCRATCH | 8..F read 0
//
// Build option
//   REGBANK_6502_PWM_EN  adds register 8 = PWM duty (reset 8'hFF) and gates
//                        led with a free-running 8-bit PWM counter.
// -----------------------------------------------------------------------------
module regbank_6502 #(
   parameter int unsigned PRESCALE = 50,
   parameter logic [7:0]  LED_RST  = 8'h00
) (
   input  logic                 clk_int50,
   input  logic                 rst,
   regbank_6502_if.slave        bus,
   output logic [7:0]           led,
   output logic                 irq_n
);

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   localparam logic [3:0] A_LED     = 4'h0;
   localparam logic [3:0] A_CTRL    = 4'h1;
   localparam logic [3:0] A_RELLO   = 4'h2;
   localparam logic [3:0] A_RELHI   = 4'h3;
   localparam logic [3:0] A_CNTLO   = 4'h4;
   localparam logic [3:0] A_CNTHI   = 4'h5;
   localparam logic [3:0] A_STATUS  = 4'h6;
   localparam logic [3:0] A_SCRATCH = 4'h7;
`ifdef REGBANK_6502_PWM_EN
   localparam logic [3:0] A_DUTY    = 4'h8;
`endif

   typedef struct packed {
      logic irqen;
      logic auto_rl;
      logic en;
   } ctrl_t;

   logic [7:0]  led_q,     led_d;
   ctrl_t       ctrl_q,    ctrl_d;
   logic [15:0] reload_q,  reload_d;
   logic [15:0] cnt_q,     cnt_d;
   logic [15:0] presc_q,   presc_d;
   logic        exp_q,     exp_d;
   logic [7:0]  scratch_q, scratch_d;
   logic [7:0]  shadow_q,  shadow_d;
   logic [7:0]  rdata_q,   rdata_d;
   logic        rvalid_q,  rvalid_d;
   logic        irq_n_q,   irq_n_d;
`ifdef REGBANK_6502_PWM_EN
   logic [7:0]  duty_q,    duty_d;
   logic [7:0]  pwm_cnt_q, pwm_cnt_d;
`endif

   logic wr;
   logic rd;
   logic tick;
   logic expire;
   logic exp_clr;

   // NOTE: every signal gets a default at the top of the block so that no
   // path leaves it unassigned; this is what keeps the block free of latches.
   always_comb begin
      led_d     = led_q;
      ctrl_d    = ctrl_q;
      reload_d  = reload_q;
      cnt_d     = cnt_q;
      presc_d   = presc_q;
      scratch_d = scratch_q;
      shadow_d  = shadow_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      tick      = 1'b0;
`ifdef REGBANK_6502_PWM_EN
      duty_d    = duty_q;
      pwm_cnt_d = pwm_cnt_q + 8'd1;
`endif

      // A write collides with a read: the write wins and the read is dropped.
      wr = bus.wr_stb;
      rd = bus.rd_stb & ~bus.wr_stb;

      // Prescaler free-runs only while enabled; its wrap is the timer tick.
      if (!ctrl_q.en) begin
         presc_d = '0;
      end else if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         tick    = 1'b1;
      end else begin
         presc_d = presc_q + 16'd1;
      end

      expire = tick && (cnt_q == 16'd0);
      if (tick) begin
         if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
         end else if (ctrl_q.auto_rl) begin
            cnt_d = reload_q;
         end else begin
            ctrl_d.en = 1'b0;
         end
      end

      // Clear and set of EXP in the same cycle: set wins.
      exp_clr = wr && (bus.addr == A_STATUS) && bus.wdata[0];
      exp_d   = expire | (exp_q & ~exp_clr);

      // Bus writes come after the timer so a CTRL write overrides the
      // one-shot auto-disable in the same cycle.
      if (wr) begin
         case (bus.addr)
            A_LED:     led_d = bus.wdata;
            A_CTRL: begin
               ctrl_d = ctrl_t'(bus.wdata[2:0]);
               // Rising EN starts a fresh period from RELOAD.
               if (bus.wdata[0] && !ctrl_q.en) begin
                  cnt_d   = reload_q;
                  presc_d = '0;
               end
            end
            A_RELLO:   reload_d[7:0]  = bus.wdata;
            A_RELHI:   reload_d[15:8] = bus.wdata;
            A_SCRATCH: scratch_d      = bus.wdata;
`ifdef REGBANK_6502_PWM_EN
            A_DUTY:    duty_d         = bus.wdata;
`endif
            default: ;
         endcase
      end

      if (rd) begin
         rvalid_d = 1'b1;
         case (bus.addr)
            A_LED:     rdata_d = led_q;
            A_CTRL:    rdata_d = {5'b0, ctrl_q};
            A_RELLO:   rdata_d = reload_q[7:0];
            A_RELHI:   rdata_d = reload_q[15:8];
            A_CNTLO: begin
               // Freeze the high byte so a following CNTHI read matches.
               rdata_d  = cnt_q[7:0];
               shadow_d = cnt_q[15:8];
            end
            A_CNTHI:   rdata_d = shadow_q;
            A_STATUS:  rdata_d = {7'b0, exp_q};
            A_SCRATCH: rdata_d = scratch_q;
`ifdef REGBANK_6502_PWM_EN
            A_DUTY:    rdata_d = duty_q;
`endif
            default:   rdata_d = 8'h00;
         endcase
      end

      irq_n_d = ~(exp_q & ctrl_q.irqen);
   end

   // NOTE: state is updated with non-blocking assignments only, so every flop
   // samples the values from before the edge regardless of statement order.
   always_ff @(posedge clk_int50) begin
      if (rst) begin
         led_q     <= LED_RST;
         ctrl_q    <= '0;
         reload_q  <= '0;
         cnt_q     <= '0;
         presc_q   <= '0;
         exp_q     <= 1'b0;
         scratch_q <= '0;
         shadow_q  <= '0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         irq_n_q   <= 1'b1;
`ifdef REGBANK_6502_PWM_EN
         duty_q    <= 8'hFF;
         pwm_cnt_q <= '0;
`endif
      end else begin
         led_q     <= led_d;
         ctrl_q    <= ctrl_d;
         reload_q  <= reload_d;
         cnt_q     <= cnt_d;
         presc_q   <= presc_d;
         exp_q     <= exp_d;
         scratch_q <= scratch_d;
         shadow_q  <= shadow_d;
         rdata_q   <= rdata_d;
         rvalid_q  <= rvalid_d;
         irq_n_q   <= irq_n_d;
`ifdef REGBANK_6502_PWM_EN
         duty_q    <= duty_d;
         pwm_cnt_q <= pwm_cnt_d;
`endif
      end
   end

`ifdef REGBANK_6502_PWM_EN
   // Duty 8'hFF lights 255 of 256 cycles; 8'h00 keeps the LEDs dark.
   assign led = led_q & {8{pwm_cnt_q < duty_q}};
`else
   assign led = led_q;
`endif

   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;
   assign irq_n      = irq_n_q;

endmodule

// File: tb/tb_regbank_6502.sv
// -----------------------------------------------------------------------------
// tb_regbank_6502
// Self-checking bench for regbank_6502 built with PRESCALE=4. Register-map
// behaviour is driven from a vector table and from random traffic compared
// against a register-array model; the timer is compared against a closed-form
// model of counter value and expiry time measured in clock edges since enable.
// -----------------------------------------------------------------------------
module tb_regbank_6502;

   localparam int P = 4;

   logic       clk_int50 = 1'b0;
   logic       rst       = 1'b1;
   logic [7:0] led;
   logic       irq_n;

   regbank_6502_if bus_if ();

   regbank_6502 #(.PRESCALE(P), .LED_RST(8'h00)) dut (
      .clk_int50 (clk_int50),
      .rst       (rst),
      .bus       (bus_if),
      .led       (led),
      .irq_n     (irq_n)
   );

   always #5 clk_int50 = ~clk_int50;

   int cyc = 0;
   always @(posedge clk_int50) cyc <= cyc + 1;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       wr;
      logic       rd;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic       rvalid;
      logic [7:0] rdata;
      logic [7:0] led;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk_int50);
      #1;
   endtask

   task automatic go_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset();
      bus_if.wr_stb = 1'b0;
      bus_if.rd_stb = 1'b0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
      bus_if.addr   = a;
      bus_if.wdata  = d;
      bus_if.wr_stb = 1'b1;
      step();
      bus_if.wr_stb = 1'b0;
   endtask

   task automatic read_check(input string name, input logic [3:0] a, input logic [7:0] exp);
      bus_if.addr   = a;
      bus_if.rd_stb = 1'b1;
      step();
      bus_if.rd_stb = 1'b0;
      check({name, "_rvalid"}, 16'(bus_if.rvalid), 16'd1);
      check(name, 16'(bus_if.rdata), 16'(exp));
   endtask

   // Timer value after m edges since the enabling write.
   function automatic int cnt_model(input int m, input int r, input bit auto_rl);
      int ticks;
      ticks = m / P;
      if (auto_rl) return r - (ticks % (r + 1));
      return (ticks > r) ? 0 : r - ticks;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int         e;
      logic [7:0] m_reg [16];
      logic [7:0] exp_rd;
      logic       w, r;
      logic [3:0] a;
      logic [7:0] d;
      int         rl;
      bit         au;
      int         m;
      int         on_cnt;

      bus_if.wr_stb = 1'b0;
      bus_if.rd_stb = 1'b0;
      bus_if.addr   = '0;
      bus_if.wdata  = '0;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_led", 16'(led), 16'h00);
      check("rst_irq_n", 16'(irq_n), 16'd1);
      check("rst_rvalid", 16'(bus_if.rvalid), 16'd0);
      for (int i = 0; i < 16; i++) begin
`ifdef REGBANK_6502_PWM_EN
         read_check($sformatf("rst_rd%0d", i), 4'(i), (i == 8) ? 8'hFF : 8'h00);
`else
         read_check($sformatf("rst_rd%0d", i), 4'(i), 8'h00);
`endif
      end

      // ---------------- vector table ----------------
      do_reset();
      vecs.push_back('{1'b1, 1'b0, 4'h0, 8'hA5, 1'b0, 8'h00, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h7, 8'h3C, 1'b0, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h0, 8'h00, 1'b1, 8'hA5, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h7, 8'h00, 1'b1, 8'h3C, 8'hA5});
      vecs.push_back('{1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 8'h3C, 8'hA5});
      vecs.push_back('{1'b1, 1'b1, 4'h7, 8'h11, 1'b0, 8'h3C, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h7, 8'h00, 1'b1, 8'h11, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h1, 8'hF8, 1'b0, 8'h11, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h1, 8'h06, 1'b0, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h1, 8'h00, 1'b1, 8'h06, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h1, 8'h00, 1'b0, 8'h06, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h2, 8'h34, 1'b0, 8'h06, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h3, 8'h12, 1'b0, 8'h06, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h2, 8'h00, 1'b1, 8'h34, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h3, 8'h00, 1'b1, 8'h12, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h9, 8'h77, 1'b0, 8'h12, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h9, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'hF, 8'h5A, 1'b0, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'hF, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h8, 8'h55, 1'b0, 8'h00, 8'hA5});
`ifdef REGBANK_6502_PWM_EN
      vecs.push_back('{1'b0, 1'b1, 4'h8, 8'h00, 1'b1, 8'h55, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h8, 8'hFF, 1'b0, 8'h55, 8'hA5});
`else
      vecs.push_back('{1'b0, 1'b1, 4'h8, 8'h00, 1'b1, 8'h00, 8'hA5});
`endif
      vecs.push_back('{1'b1, 1'b0, 4'h6, 8'hFF, 1'b0, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h6, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h4, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b0, 1'b1, 4'h5, 8'h00, 1'b1, 8'h00, 8'hA5});
      vecs.push_back('{1'b1, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 8'h00});
      foreach (vecs[i]) begin
         bus_if.wr_stb = vecs[i].wr;
         bus_if.rd_stb = vecs[i].rd;
         bus_if.addr   = vecs[i].addr;
         bus_if.wdata  = vecs[i].wdata;
         step();
         bus_if.wr_stb = 1'b0;
         bus_if.rd_stb = 1'b0;
         check($sformatf("vec%0d_rvalid", i), 16'(bus_if.rvalid), 16'(vecs[i].rvalid));
         check($sformatf("vec%0d_rdata", i), 16'(bus_if.rdata), 16'(vecs[i].rdata));
`ifndef REGBANK_6502_PWM_EN
         check($sformatf("vec%0d_led", i), 16'(led), 16'(vecs[i].led));
`endif
      end

      // ---------------- one-shot: RELOAD=3, CTRL=05 ----------------
      do_reset();
      bus_write(4'h2, 8'h03);
      bus_write(4'h3, 8'h00);
      bus_write(4'h1, 8'h05);
      e = cyc;
      go_to(e + 15);
      read_check("oneshot_status_early", 4'h6, 8'h00);
      check("oneshot_irq_at_exp", 16'(irq_n), 16'd1);
      step();
      check("oneshot_irq_low", 16'(irq_n), 16'd0);
      read_check("oneshot_ctrl", 4'h1, 8'h04);
      read_check("oneshot_status", 4'h6, 8'h01);
      bus_write(4'h6, 8'h01);
      step();
      check("oneshot_irq_cleared", 16'(irq_n), 16'd1);

      // ---------------- auto-reload with reload change ----------------
      do_reset();
      bus_write(4'h2, 8'h02);
      bus_write(4'h1, 8'h07);
      e = cyc;
      go_to(e + 12);
      check("auto_irq_pre1", 16'(irq_n), 16'd1);
      step();
      check("auto_irq_exp1", 16'(irq_n), 16'd0);
      bus_write(4'h6, 8'h01);
      step();
      check("auto_irq_clr1", 16'(irq_n), 16'd1);
      bus_write(4'h2, 8'h05);
      go_to(e + 24);
      check("auto_irq_pre2", 16'(irq_n), 16'd1);
      step();
      check("auto_irq_exp2", 16'(irq_n), 16'd0);
      read_check("auto_cnt_new_reload", 4'h4, 8'h05);
      bus_write(4'h6, 8'h01);
      go_to(e + 48);
      check("auto_irq_pre3", 16'(irq_n), 16'd1);
      step();
      check("auto_irq_exp3", 16'(irq_n), 16'd0);

      // ---------------- clear on exact expiry edge ----------------
      do_reset();
      bus_write(4'h2, 8'h01);
      bus_write(4'h1, 8'h05);
      e = cyc;
      go_to(e + 7);
      bus_write(4'h6, 8'h01);
      read_check("race_status", 4'h6, 8'h01);
      check("race_irq", 16'(irq_n), 16'd0);

      // ---------------- atomic 16-bit counter read ----------------
      do_reset();
      bus_write(4'h2, 8'h00);
      bus_write(4'h3, 8'h01);
      bus_write(4'h1, 8'h01);
      e = cyc;
      go_to(e + 2);
      read_check("atomic_lo", 4'h4, 8'h00);
      go_to(e + 4);
      read_check("atomic_hi", 4'h5, 8'h01);
      read_check("atomic_lo2", 4'h4, 8'hFF);
      read_check("atomic_hi2", 4'h5, 8'h00);

      // ---------------- reset mid-count ----------------
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_irq_n", 16'(irq_n), 16'd1);
      check("midrst_rvalid", 16'(bus_if.rvalid), 16'd0);
      read_check("midrst_ctrl", 4'h1, 8'h00);
      read_check("midrst_relhi", 4'h3, 8'h00);
      read_check("midrst_cnthi", 4'h5, 8'h00);
      repeat (10) step();
      read_check("midrst_cntlo", 4'h4, 8'h00);
      read_check("midrst_status", 4'h6, 8'h00);

      // ---------------- random register traffic, timer off ----------------
      do_reset();
      foreach (m_reg[i]) m_reg[i] = 8'h00;
`ifdef REGBANK_6502_PWM_EN
      m_reg[8] = 8'hFF;
`endif
      exp_rd = 8'h00;
      for (int n = 0; n < 300; n++) begin
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         a = 4'($urandom_range(0, 15));
         d = 8'($urandom);
         if (a == 4'h1) d = d & 8'hFE;
         bus_if.wr_stb = w;
         bus_if.rd_stb = r;
         bus_if.addr   = a;
         bus_if.wdata  = d;
         step();
         bus_if.wr_stb = 1'b0;
         bus_if.rd_stb = 1'b0;
         if (r && !w) begin
            case (a)
               4'h0, 4'h2, 4'h3, 4'h7: exp_rd = m_reg[a];
               4'h1:                   exp_rd = m_reg[a] & 8'h07;
`ifdef REGBANK_6502_PWM_EN
               4'h8:                   exp_rd = m_reg[a];
`endif
               default:                exp_rd = 8'h00;
            endcase
         end
         if (w) begin
            case (a)
               4'h0, 4'h1, 4'h2, 4'h3, 4'h7: m_reg[a] = d;
`ifdef REGBANK_6502_PWM_EN
               4'h8:                         m_reg[a] = d;
`endif
               default: ;
            endcase
         end
         check("rnd_rvalid", 16'(bus_if.rvalid), 16'(r && !w));
         check("rnd_rdata", 16'(bus_if.rdata), 16'(exp_rd));
`ifndef REGBANK_6502_PWM_EN
         check("rnd_led", 16'(led), 16'(m_reg[0]));
`endif
      end

      // ---------------- random timer runs ----------------
      for (int run = 0; run < 8; run++) begin
         rl = $urandom_range(0, 9);
         au = 1'($urandom_range(0, 1));
         do_reset();
         bus_write(4'h2, 8'(rl));
         bus_write(4'h1, {5'b0, 1'b1, au, 1'b1});
         e = cyc;
         for (int k = 0; k < (rl + 1) * P * 2 + 6; k++) begin
            r = 1'($urandom_range(0, 1));
            bus_if.addr   = 4'h4;
            bus_if.rd_stb = r;
            step();
            bus_if.rd_stb = 1'b0;
            m = cyc - e;
            check("tmr_irq_n", 16'(irq_n), 16'(!(m >= (rl + 1) * P + 1)));
            check("tmr_rvalid", 16'(bus_if.rvalid), 16'(r));
            if (r) check("tmr_cnt", 16'(bus_if.rdata), 16'(cnt_model(m - 1, rl, au)));
         end
      end

`ifdef REGBANK_6502_PWM_EN
      // ---------------- PWM gating ----------------
      do_reset();
      bus_write(4'h0, 8'hFF);
      bus_write(4'h8, 8'h40);
      read_check("pwm_duty_rd", 4'h8, 8'h40);
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         if (led == 8'hFF) on_cnt++;
      end
      check("pwm_on_count", 16'(on_cnt), 16'd64);
`else
      on_cnt = 0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
